// File: rtl/opc_history_if.sv
// Bus between the debug/spy side and the OPC history buffer.
// Capture strobe: PC_IN is taken on any rising edge where PC_VALID=1, FREEZE=0 and CLEAR=0.
// There is no back-pressure. Reads issue RD_IDX every cycle, and RD_DATA/RD_VALID answer one edge later.
interface opc_history_if #(
  parameter int PC_WIDTH = 14,
  parameter int PTR_BITS = 3
);
  logic [PC_WIDTH-1:0] PC_IN;
  logic                PC_VALID;
  logic                FREEZE;
  logic                CLEAR;
  logic [PTR_BITS-1:0] RD_IDX;
  logic [PC_WIDTH-1:0] RD_DATA;
  logic                RD_VALID;
  logic [PTR_BITS:0]   COUNT;

  modport master (
    output PC_IN, PC_VALID, FREEZE, CLEAR, RD_IDX,
    input  RD_DATA, RD_VALID, COUNT
  );

  modport slave (
    input  PC_IN, PC_VALID, FREEZE, CLEAR, RD_IDX,
    output RD_DATA, RD_VALID, COUNT
  );
endinterface

// File: rtl/opc_history.sv
// Circular history of the last DEPTH program-counter values. Entries are read back by age,
// with 0 = newest, and the read data is registered.
module opc_history #(
  parameter int PC_WIDTH = 14,
  parameter int DEPTH    = 8,
  parameter int PTR_BITS = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  opc_history_if.slave  bus
);

  localparam logic [PTR_BITS:0] FULL = (PTR_BITS+1)'(DEPTH);

  logic [PC_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_BITS-1:0] wptr_q, wptr_d;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [PTR_BITS:0]   count_q, count_d;
  logic [PC_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                flush;
  logic                capture;

  assign flush   = RESET | bus.CLEAR;
  assign capture = bus.PC_VALID & ~bus.FREEZE & ~flush;

  // The read uses pre-edge pointer and storage, so a same-edge capture is not visible yet.
  always_comb begin
    wptr_d     = wptr_q;
    count_d    = count_q;
    rd_ptr     = wptr_q - PTR_BITS'(1) - bus.RD_IDX;
    rd_valid_d = ({1'b0, bus.RD_IDX} < count_q);
    rd_data_d  = rd_valid_d ? mem_q[rd_ptr] : '0;
    if (capture) begin
      wptr_d  = wptr_q + PTR_BITS'(1);
      count_d = (count_q == FULL) ? count_q : count_q + (PTR_BITS+1)'(1);
    end
    if (flush) begin
      wptr_d     = '0;
      count_d    = '0;
      rd_valid_d = 1'b0;
      rd_data_d  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    wptr_q     <= wptr_d;
    count_q    <= count_d;
    rd_data_q  <= rd_data_d;
    rd_valid_q <= rd_valid_d;
  end

  always_ff @(posedge CLK) begin
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (capture) begin
      mem_q[wptr_q] <= bus.PC_IN;
    end
  end

  assign bus.RD_DATA  = rd_data_q;
  assign bus.RD_VALID = rd_valid_q;
  assign bus.COUNT    = count_q;

endmodule
